// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder
//
// Responder for the CHIP-8 memory request port. Accepts one single-byte
// read or write at a time and services it against the program RAM BRAM
// (RAM_AW address bits) or the VRAM framebuffer BRAM (VRAM_AW address bits).
// Read data returns a fixed number of cycles after acceptance.
// READ_LATENCY is the BRAM read latency and is expected to be in 1..4.
//
// Optional feature, selected by defining the macro CHIP8_MEM_BOUNDS_ERR_EN:
// requests with nonzero address bits above the selected BRAM's width raise a
// sticky err_out, writes are dropped and reads return 0x00. Without the
// macro the upper address bits wrap silently and err_out is tied low.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | ready for a request (once out of reset)
// ST_WRITE     | selected BRAM write enable high for this single cycle
// ST_READ_WAIT | address presented, down-counting the BRAM read latency
// ST_RESPOND   | rsp_valid pulse; a new request may be accepted this cycle

module chip8_mem_responder #(
    parameter int RAM_AW       = 12,
    parameter int VRAM_AW      = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               req_valid_in,
    input  logic               req_we_in,
    input  logic               req_type_in,
    input  logic [15:0]        req_addr_in,
    input  logic [7:0]         req_data_in,
    output logic               req_ready_out,
    output logic               rsp_valid_out,
    output logic [7:0]         rsp_data_out,
    output logic [RAM_AW-1:0]  ram_addr_out,
    output logic               ram_we_out,
    output logic [7:0]         ram_din_out,
    input  logic [7:0]         ram_dout_in,
    output logic [VRAM_AW-1:0] vram_addr_out,
    output logic               vram_we_out,
    output logic [7:0]         vram_din_out,
    input  logic [7:0]         vram_dout_in,
    output logic               err_out
);

    // The down-counter is loaded with the latency on acceptance and the
    // BRAM output is sampled on the edge where it has already reached zero,
    // giving READ_LATENCY+1 cycles in ST_READ_WAIT.
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        ready_en_q;
    logic        type_q;
    logic        oob_q;
    logic        accept;
    logic        capture;

    // Ready is held low through reset and for the first edge after release,
    // so an initiator never sees ready while the responder is still in reset.
    assign req_ready_out = ready_en_q &
                           ((state_q == ST_IDLE) || (state_q == ST_RESPOND));
    assign accept        = req_valid_in & req_ready_out;

    // Ready enable: rises on the first clock edge after reset release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // FSM state register and latency down-counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state and per-state outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        rsp_valid_out = 1'b0;
        ram_we_out    = 1'b0;
        vram_we_out   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESPOND: begin
                rsp_valid_out = (state_q == ST_RESPOND);
                if (accept) begin
                    state_d = req_we_in ? ST_WRITE : ST_READ_WAIT;
                    cnt_d   = LAT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // An out-of-range write still spends its busy cycle here,
                // it just never asserts a write enable.
                ram_we_out  = ~type_q & ~oob_q;
                vram_we_out = type_q & ~oob_q;
                state_d     = ST_IDLE;
            end
            ST_READ_WAIT: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Remember which BRAM the accepted request targets.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            type_q <= 1'b0;
        end else if (accept) begin
            type_q <= req_type_in;
        end
    end

    // Program RAM port: address/data only move when RAM is selected,
    // otherwise they hold their last value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ram_addr_out <= '0;
            ram_din_out  <= 8'h00;
        end else if (accept && !req_type_in) begin
            ram_addr_out <= req_addr_in[RAM_AW-1:0];
            ram_din_out  <= req_data_in;
        end
    end

    // VRAM port: byte address is row*8 + column byte, taken straight from
    // the low address bits; holds its value while RAM is selected.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vram_addr_out <= '0;
            vram_din_out  <= 8'h00;
        end else if (accept && req_type_in) begin
            vram_addr_out <= req_addr_in[VRAM_AW-1:0];
            vram_din_out  <= req_data_in;
        end
    end

    // Read data capture; the value is held until the next read completes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_data_out <= 8'h00;
        end else if (capture) begin
            if (oob_q) begin
                rsp_data_out <= 8'h00;
            end else if (type_q) begin
                rsp_data_out <= vram_dout_in;
            end else begin
                rsp_data_out <= ram_dout_in;
            end
        end
    end

`ifdef CHIP8_MEM_BOUNDS_ERR_EN
    logic oob_req;
    logic err_q;

    // A request is out of range when any address bit above the selected
    // BRAM's width is set.
    assign oob_req = req_type_in ? ((req_addr_in >> VRAM_AW) != 16'd0)
                                 : ((req_addr_in >> RAM_AW) != 16'd0);
    assign err_out = err_q;

    // Out-of-range flag for the request in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            oob_q <= 1'b0;
        end else if (accept) begin
            oob_q <= oob_req;
        end
    end

    // Sticky bounds error, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q <= 1'b0;
        end else if (accept && oob_req) begin
            err_q <= 1'b1;
        end
    end
`else
    // Upper address bits are deliberately ignored: addresses wrap.
    logic unused_addr_bits;

    assign unused_addr_bits = ^req_addr_in;
    assign oob_q            = 1'b0;
    assign err_out          = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Testbench for chip8_mem_responder: BRAM behavioural models, a directed
// vector table, hand-written multi-cycle sequences and a randomized phase
// checked against a transaction-level memory model.
`timescale 1ns/1ps

module tb_chip8_mem_responder;

    localparam int RAM_AW  = 12;
    localparam int VRAM_AW = 8;
    localparam int LAT     = 2;
`ifdef CHIP8_MEM_BOUNDS_ERR_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic               req_valid_in;
    logic               req_we_in;
    logic               req_type_in;
    logic [15:0]        req_addr_in;
    logic [7:0]         req_data_in;
    logic               req_ready_out;
    logic               rsp_valid_out;
    logic [7:0]         rsp_data_out;
    logic [RAM_AW-1:0]  ram_addr_out;
    logic               ram_we_out;
    logic [7:0]         ram_din_out;
    logic [7:0]         ram_dout_in;
    logic [VRAM_AW-1:0] vram_addr_out;
    logic               vram_we_out;
    logic [7:0]         vram_din_out;
    logic [7:0]         vram_dout_in;
    logic               err_out;

    int n_tests = 0;
    int n_fail  = 0;

    chip8_mem_responder #(
        .RAM_AW       (RAM_AW),
        .VRAM_AW      (VRAM_AW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_valid_in  (req_valid_in),
        .req_we_in     (req_we_in),
        .req_type_in   (req_type_in),
        .req_addr_in   (req_addr_in),
        .req_data_in   (req_data_in),
        .req_ready_out (req_ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_data_out  (rsp_data_out),
        .ram_addr_out  (ram_addr_out),
        .ram_we_out    (ram_we_out),
        .ram_din_out   (ram_din_out),
        .ram_dout_in   (ram_dout_in),
        .vram_addr_out (vram_addr_out),
        .vram_we_out   (vram_we_out),
        .vram_din_out  (vram_din_out),
        .vram_dout_in  (vram_dout_in),
        .err_out       (err_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- BRAM models (synchronous, LAT-cycle read) ----------
    logic [7:0] ram_mem   [4096];
    logic [7:0] vram_mem  [256];
    logic [7:0] ram_pipe  [LAT];
    logic [7:0] vram_pipe [LAT];

    always @(posedge clk_in) begin
        ram_pipe[0]  <= ram_mem[ram_addr_out];
        vram_pipe[0] <= vram_mem[vram_addr_out];
        for (int i = 1; i < LAT; i++) begin
            ram_pipe[i]  <= ram_pipe[i-1];
            vram_pipe[i] <= vram_pipe[i-1];
        end
        if (ram_we_out)  ram_mem[ram_addr_out]   = ram_din_out;
        if (vram_we_out) vram_mem[vram_addr_out] = vram_din_out;
    end

    assign ram_dout_in  = ram_pipe[LAT-1];
    assign vram_dout_in = vram_pipe[LAT-1];

    // ---------------- Reference model (transaction level) ----------------
    logic [7:0] ram_ref  [4096];
    logic [7:0] vram_ref [256];
    logic       err_exp = 1'b0;

    function automatic logic [7:0] init_ram(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [7:0] init_vram(input int i);
        return 8'(i ^ 8'hC3);
    endfunction

    function automatic bit addr_oob(input bit typ, input logic [15:0] a);
        return BOUNDS && (typ ? (a >= 16'd256) : (a >= 16'd4096));
    endfunction

    function automatic logic [15:0] masked(input bit typ, input logic [15:0] a);
        return typ ? (a % 16'd256) : (a % 16'd4096);
    endfunction

    function automatic logic [7:0] model_read(input bit typ, input logic [15:0] a);
        if (addr_oob(typ, a)) return 8'h00;
        return typ ? vram_ref[masked(typ, a)] : ram_ref[masked(typ, a)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("ready_wait", 32'(req_ready_out), 32'd1);
    endtask

    task automatic do_write(input bit typ, input logic [15:0] a, input logic [7:0] d);
        bit          o;
        logic [15:0] ma;
        o  = addr_oob(typ, a);
        ma = masked(typ, a);
        wait_ready();
        req_we_in    = 1'b1;
        req_type_in  = typ;
        req_addr_in  = a;
        req_data_in  = d;
        req_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        if (!o) begin
            if (typ) vram_ref[ma] = d;
            else     ram_ref[ma]  = d;
        end
        err_exp = err_exp | o;
        chk("wr_we_sel",   32'(typ ? vram_we_out : ram_we_out), 32'(!o));
        chk("wr_we_other", 32'(typ ? ram_we_out : vram_we_out), 32'd0);
        chk("wr_addr",     typ ? 32'(vram_addr_out) : 32'(ram_addr_out), 32'(ma));
        chk("wr_din",      typ ? 32'(vram_din_out) : 32'(ram_din_out), 32'(d));
        chk("wr_ready_busy", 32'(req_ready_out), 32'd0);
        chk("wr_no_rsp",   32'(rsp_valid_out), 32'd0);
        @(negedge clk_in);
        chk("wr_we_drop",    32'(ram_we_out | vram_we_out), 32'd0);
        chk("wr_ready_back", 32'(req_ready_out), 32'd1);
        chk("wr_err",        32'(err_out), 32'(err_exp));
    endtask

    // Returns in the response cycle (negedge), leaving the caller free to
    // issue the next request while the responder is in its respond state.
    task automatic do_read(input bit typ, input logic [15:0] a, input logic [7:0] exp,
                           input bit inject);
        bit          o;
        logic [15:0] ma;
        o  = addr_oob(typ, a);
        ma = masked(typ, a);
        wait_ready();
        req_we_in    = 1'b0;
        req_type_in  = typ;
        req_addr_in  = a;
        req_data_in  = 8'($urandom);
        req_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        err_exp = err_exp | o;
        chk("rd_addr", typ ? 32'(vram_addr_out) : 32'(ram_addr_out), 32'(ma));
        chk("rd_err",  32'(err_out), 32'(err_exp));
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) @(negedge clk_in);
            chk("rd_rsp_valid", 32'(rsp_valid_out), 32'(k == LAT + 1));
            chk("rd_ready",     32'(req_ready_out), 32'(k == LAT + 1));
            chk("rd_no_we",     32'(ram_we_out | vram_we_out), 32'd0);
            if (inject && k == 1) begin
                req_we_in    = 1'b1;
                req_type_in  = 1'b0;
                req_addr_in  = 16'h0300;
                req_data_in  = 8'hEE;
                req_valid_in = 1'b1;
            end
            if (inject && k == 2) req_valid_in = 1'b0;
        end
        chk("rd_data", 32'(rsp_data_out), 32'(exp));
    endtask

    typedef struct {
        bit          we;
        bit          typ;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          typ;
        logic [15:0] a;
        logic [7:0]  last;
        int          mism;

        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = init_ram(i);
            ram_ref[i] = init_ram(i);
        end
        for (int i = 0; i < 256; i++) begin
            vram_mem[i] = init_vram(i);
            vram_ref[i] = init_vram(i);
        end

        vecs[0]  = '{1'b1, 1'b0, 16'h0200, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 16'h0200, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 1'b1, 16'h00FF, 8'h3F, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 16'h00FF, 8'h00, 8'h3F};
        vecs[4]  = '{1'b0, 1'b0, 16'h00FF, 8'h00, init_ram(255)};
        vecs[5]  = '{1'b1, 1'b1, 16'h0000, 8'h81, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h81};
        vecs[7]  = '{1'b0, 1'b1, 16'h00FE, 8'h00, init_vram(254)};
        vecs[8]  = '{1'b1, 1'b0, 16'h0FFF, 8'h5C, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 16'h0FFF, 8'h00, 8'h5C};
        vecs[10] = '{1'b1, 1'b0, 16'h1200, 8'h11, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 16'h0200, 8'h00, BOUNDS ? 8'hA5 : 8'h11};
        vecs[12] = '{1'b0, 1'b0, 16'h1200, 8'h00, BOUNDS ? 8'h00 : 8'h11};
        vecs[13] = '{1'b0, 1'b1, 16'h01FF, 8'h00, BOUNDS ? 8'h00 : 8'h3F};

        rst_n_in     = 1'b1;
        req_valid_in = 1'b0;
        req_we_in    = 1'b0;
        req_type_in  = 1'b0;
        req_addr_in  = 16'h0000;
        req_data_in  = 8'h00;
        #2 rst_n_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_ready",     32'(req_ready_out), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data_out), 32'd0);
        chk("rst_we",        32'(ram_we_out | vram_we_out), 32'd0);
        chk("rst_ram_addr",  32'(ram_addr_out), 32'd0);
        chk("rst_ram_din",   32'(ram_din_out), 32'd0);
        chk("rst_vram_addr", 32'(vram_addr_out), 32'd0);
        chk("rst_vram_din",  32'(vram_din_out), 32'd0);
        chk("rst_err",       32'(err_out), 32'd0);
        rst_n_in = 1'b1;
        #1 chk("rel_ready_pre_edge", 32'(req_ready_out), 32'd0);
        @(negedge clk_in);
        chk("rel_ready_post_edge", 32'(req_ready_out), 32'd1);
        chk("rel_rsp_valid",       32'(rsp_valid_out), 32'd0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) do_write(vecs[i].typ, vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].typ, vecs[i].addr, vecs[i].exp, 1'b0);
        end

        // Request during READ_WAIT ignored; request in RESPOND accepted
        do_read(1'b0, 16'h0200, model_read(1'b0, 16'h0200), 1'b1);
        do_read(1'b1, 16'h00FF, 8'h3F, 1'b0);
        do_read(1'b0, 16'h0300, init_ram(16'h0300), 1'b0);
        last = init_ram(16'h0300);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("idle_no_rsp",    32'(rsp_valid_out), 32'd0);
            chk("idle_data_hold", 32'(rsp_data_out), 32'(last));
        end

        // Reset one cycle after a read is accepted
        wait_ready();
        req_we_in    = 1'b0;
        req_type_in  = 1'b0;
        req_addr_in  = 16'h0200;
        req_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        rst_n_in     = 1'b0;
        err_exp      = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready_out), 32'd0);
        chk("midrst_rsp",   32'(rsp_valid_out), 32'd0);
        chk("midrst_data",  32'(rsp_data_out), 32'd0);
        chk("midrst_err",   32'(err_out), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 chk("midrst_ready_pre_edge", 32'(req_ready_out), 32'd0);
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk_in);
            chk("midrst_no_rsp",     32'(rsp_valid_out), 32'd0);
            chk("midrst_ready_back", 32'(req_ready_out), 32'd1);
        end
        do_read(1'b0, 16'h0200, model_read(1'b0, 16'h0200), 1'b0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 120; t++) begin
            typ = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else if (typ)                  a = 16'($urandom_range(0, 15));
            else                           a = 16'h0200 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(typ, a, 8'($urandom));
            end else begin
                do_read(typ, a, model_read(typ, a), 1'b0);
                if ($urandom_range(0, 2) == 0) begin
                    last = model_read(typ, a);
                    @(negedge clk_in);
                    chk("rand_idle_no_rsp", 32'(rsp_valid_out), 32'd0);
                    chk("rand_data_hold",   32'(rsp_data_out), 32'(last));
                end
            end
        end

        // Every byte written landed where the model expects, nowhere else
        @(negedge clk_in);
        mism = 0;
        for (int i = 0; i < 4096; i++) if (ram_mem[i] !== ram_ref[i]) mism++;
        for (int i = 0; i < 256; i++)  if (vram_mem[i] !== vram_ref[i]) mism++;
        chk("mem_image", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
